// File: rtl/scanning_decoder_pkg.sv
// rtl/scanning_decoder_pkg.sv - shared types and sizing helpers for the scanning decoder
package decoder_pkg;

  // Operating mode as seen on the mode input and held in the stored-mode register.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Prescaler width: wide enough to hold PRESCALE itself, so PRESCALE=1 still yields one bit.
  function automatic int presc_width(input int prescale);
    return $clog2(prescale + 1);
  endfunction

endpackage

// File: rtl/scanning_decoder_if.sv
// rtl/scanning_decoder_if.sv - select/enable inputs and decoded outputs of the scanning decoder
interface scanning_decoder_if
  import decoder_pkg::*;
#(
  parameter int N     = 4,
  parameter int COUNT = 2 ** N
);

  logic             ena_i;
  mode_e            mode_i;
  logic [N-1:0]     in_i;
  logic [COUNT-1:0] out_o;
  logic [N-1:0]     index_o;
  logic             wrap_o;

  // Driver side: supplies enable, mode and select, observes the decoded result.
  modport master (
    output ena_i, mode_i, in_i,
    input  out_o, index_o, wrap_o
  );

  // Decoder side.
  modport slave (
    input  ena_i, mode_i, in_i,
    output out_o, index_o, wrap_o
  );

endinterface

// File: rtl/scanning_decoder_onehot.sv
// rtl/scanning_decoder_onehot.sv - combinational binary to one-hot decode with out-of-range flag
module binary_to_onehot #(
  parameter int N     = 4,
  parameter int COUNT = 2 ** N
) (
  input  logic [N-1:0]     bin_i,
  output logic [COUNT-1:0] onehot_o,
  output logic             oor_o
);

  // Only positions below COUNT exist; any other code leaves the word empty and raises oor_o.
  always_comb begin
    onehot_o = '0;
    oor_o    = 1'b1;
    for (int k = 0; k < COUNT; k++) begin
      if (bin_i == k[N-1:0]) begin
        onehot_o[k] = 1'b1;
        oor_o       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scanning_decoder.sv
// rtl/scanning_decoder.sv - registered one-hot decoder with direct and prescaled scan modes
module scanning_decoder
  import decoder_pkg::*;
#(
  parameter int N        = 4,
  parameter int COUNT    = 2 ** N,
  parameter int PRESCALE = 1000
) (
  input logic          clk,
  input logic          rst,
  scanning_decoder_if.slave bus
);

  localparam int             PW         = presc_width(PRESCALE);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]   INDEX_LAST = N'(COUNT - 1);

  mode_e            mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [N-1:0]     index_q, index_d;
  logic [COUNT-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  logic [N-1:0]     idx_cand;
  logic [COUNT-1:0] cand_onehot;
  logic             cand_oor;
  logic             mode_change;
  logic             presc_done;

  assign mode_change = (bus.mode_i != mode_q);
  assign presc_done  = (presc_q == PRESC_LAST);

  // State register: reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_DIRECT;
      presc_q <= '0;
      index_q <= '0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      index_q <= index_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next index candidate: a mode change restarts at 0 and beats a terminal count;
  // with ena low everything holds so a paused scan keeps its phase.
  always_comb begin
    mode_d   = mode_q;
    presc_d  = presc_q;
    idx_cand = index_q;
    wrap_d   = 1'b0;
    if (bus.ena_i) begin
      mode_d = bus.mode_i;
      if (mode_change) begin
        idx_cand = '0;
        presc_d  = '0;
      end else if (mode_q == MODE_DIRECT) begin
        idx_cand = bus.in_i;
        presc_d  = '0;
      end else if (presc_done) begin
        presc_d = '0;
        if (index_q == INDEX_LAST) begin
          idx_cand = '0;
          wrap_d   = 1'b1;
        end else begin
          idx_cand = index_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  binary_to_onehot #(
    .N     (N),
    .COUNT (COUNT)
  ) u_onehot (
    .bin_i    (idx_cand),
    .onehot_o (cand_onehot),
    .oor_o    (cand_oor)
  );

  // Output word follows the decoded candidate; an out-of-range select blanks out and keeps the old index.
  always_comb begin
    index_d = cand_oor ? index_q : idx_cand;
    out_d   = (bus.ena_i && !cand_oor) ? cand_onehot : '0;
  end

  assign bus.out_o   = out_q;
  assign bus.index_o = index_q;
  assign bus.wrap_o  = wrap_q;

endmodule

// File: doc/scanning_decoder.md
# scanning_decoder

Parametrised binary-to-one-hot decoder with registered outputs and a built-in scan mode. In direct mode it decodes an N-bit select into a one-hot output word. In scan mode it steps a one-hot output through every output position at a programmable rate. It sits behind LED-matrix row drivers and multiplexed seven-segment digit selects, where it replaces cascaded fixed-width decoders plus an external counter.

## Interface
- `N`, default 4: select width in bits.
- `COUNT`, default 2**N: number of outputs; legal range 2..2**N.
- `PRESCALE`, default 1000: clock cycles per scan step; legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ena`  in  1  output enable; when low, all outputs are forced to zero.
- `mode`  in  1  0 = direct, 1 = scan.
- `in`  in  N  select value, used in direct mode only.
- `out`  out  COUNT  registered one-hot output; all-zero when disabled or the select is out of range.
- `index`  out  N  registered binary index of the currently asserted bit.
- `wrap`  out  1  one-cycle pulse when the scan index wraps from COUNT-1 to 0.

## Operation
- Reset (`rst`=1 at an edge):
  - `out`=0, `index`=0, `wrap`=0.
  - Prescaler count=0; stored mode=direct.
  - Reset overrides every other input.
- `ena`=0:
  - `out` goes to 0 at the next edge and `wrap` is 0.
  - `index`, the prescaler and the stored mode hold their values.
- Direct mode, `ena`=1:
  - If `in` < COUNT: `index`<=`in` and `out`<=1<<`in`.
  - If `in` ≥ COUNT: `out`<=0 and `index` holds.
  - `wrap`=0. The prescaler is held at 0.
- Scan mode, `ena`=1:
  - The prescaler counts 0..PRESCALE-1.
  - On the cycle it equals PRESCALE-1, it returns to 0 and `index` advances by one.
  - From COUNT-1, `index` goes to 0 and `wrap`=1 for that one cycle.
  - `out` always equals 1<<`index` of the same registered cycle.
- Mode change:
  - Stored mode is `mode` registered.
  - On any edge where `mode` differs from the stored mode, `index`<=0, `out`<=1<<0, prescaler<=0 and `wrap`=0.
  - The new mode's normal rules apply from the following edge.
- Arithmetic:
  - The prescaler is $clog2(PRESCALE+1) bits wide.
  - `index` is compared against COUNT-1 and never reaches values ≥ COUNT in scan mode.
- PRESCALE=1: `index` advances every enabled cycle.

## Timing
- Direct mode latency: 1 cycle from `in` to `out`/`index`.
- Scan step period: exactly PRESCALE enabled cycles. A full sweep takes COUNT×PRESCALE enabled cycles.
- `ena` low pauses the scan without loss of phase. Re-enabling resumes at the held prescaler value, and `out` reappears one edge after `ena` rises.
- `wrap` coincides with the edge at which `out` becomes 1<<0.
- Simultaneous events:
  - Mode change together with prescaler terminal count: the mode change wins.
  - `rst` together with anything: reset wins.
- Reset mid-scan: at the next edge the outputs take their reset values, with no partial step.

## Structure
- Package `decoder_pkg`:
  - Mode typedef: `MODE_DIRECT`=1'b0, `MODE_SCAN`=1'b1.
  - Parametrised localparam helper for the prescaler width.
- Sub-module `binary_to_onehot`:
  - Purely combinational, parametrised on N and COUNT.
  - Produces a one-hot output with an out-of-range flag.
  - Used on the next-index value feeding the `out` register.
- The top level holds the prescaler, index register, mode register and output registers.

## Test plan
- Reset: hold `rst` for 3 cycles with `ena`=1 and `mode`=1 -> `out`=0, `index`=0, `wrap`=0 throughout; first scan step occurs PRESCALE cycles after release.
- Direct decode (N=4, COUNT=16): drive `in`=0..15, one value per cycle -> `out`=1<<k and `index`=k one cycle later; `in`=9 with `ena`=0 -> `out`=16'h0000.
- Out of range (N=4, COUNT=10): `in`=12 -> `out`=0 and `index` holds the previous value; `in`=9 -> `out`=10'h200.
- Scan sweep (COUNT=4, PRESCALE=3):
  - `index` sequence is 0,1,2,3,0 with 3 cycles per value.
  - `wrap` is high only on the 3→0 edge.
  - `out` is 1,2,4,8,1.
- Pause (COUNT=4, PRESCALE=3): drop `ena` for 5 cycles in the middle of a step -> `out`=0 during the pause; the step completes after the remaining prescale cycles once `ena`=1; `index` is unchanged across the pause.
- Mode switch: switch to scan while `index`=7 in direct mode -> the next edge gives `index`=0 and `out`=1; switch during a terminal-count cycle -> `index`=0 and `wrap`=0.
